fp_mul_seq: RTL

//   Iterative IEEE-754 multiplier: the responder (DUT) end of the fp_mul a/b/rm -> result interface.

---
 rtl/fp_mul_seq.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_mul_seq.sv
// fp_mul_seq -- iterative IEEE-754 multiplier with valid/ready on both sides.
//
// One operation is held in flight. Significands are multiplied by a
// shift-add loop (one multiplier bit per cycle), then normalised, rounded
// and packed. Subnormal inputs are treated as signed zero and tiny results
// are flushed to signed zero. Special operands take the same path through
// the FSM, so latency is fixed.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a/b/rm valid
//   in_ready   block can accept an operation (IDLE only)
//   a, b       operands, WIDTH bits
//   rm         rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM,
//              anything else behaves as RNE
//   out_valid  result/flags valid
//   out_ready  consumer accepts result
//   result     product, WIDTH bits
//   flags      {invalid, divzero (always 0), overflow, underflow, inexact}
module fp_mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       rm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       flags
);

   localparam int EXP_W  = (WIDTH == 64) ? 11 : (WIDTH == 32) ? 8 : 5;
   localparam int MAN_W  = (WIDTH == 64) ? 52 : (WIDTH == 32) ? 23 : 10;
   localparam int SIG_W  = MAN_W + 1;
   localparam int PROD_W = 2 * SIG_W;
   localparam int SUM_W  = SIG_W + 1;
   localparam int XE_W   = EXP_W + 2;
   localparam int CNT_W  = $clog2(SIG_W);

   localparam logic signed [XE_W-1:0] BIAS    = XE_W'(2**(EXP_W-1) - 1);
   localparam logic signed [XE_W-1:0] EXP_MAX = XE_W'(2**EXP_W - 1);
   localparam logic signed [XE_W-1:0] EXP_ZERO = '0;

   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   if (!(WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
      $fatal(1, "fp_mul_seq: WIDTH must be 16, 32 or 64");
   end

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_RND, S_DONE} state_t;
   typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

   state_t state_q, state_d;

   // Operand decode (only meaningful on the accept edge)
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, inf_zero;
   logic inv_in;
   cls_t cls_in;

   assign ea = a[WIDTH-2:MAN_W];
   assign eb = b[WIDTH-2:MAN_W];
   assign fa = a[MAN_W-1:0];
   assign fb = b[MAN_W-1:0];

   // A zero exponent field counts as zero whether or not the fraction is set.
   assign a_zero   = (ea == '0);
   assign b_zero   = (eb == '0);
   assign a_inf    = (ea == '1) && (fa == '0);
   assign b_inf    = (eb == '1) && (fb == '0);
   assign a_nan    = (ea == '1) && (fa != '0);
   assign b_nan    = (eb == '1) && (fb != '0);
   assign inf_zero = (a_inf && b_zero) || (b_inf && a_zero);
   // A NaN with a clear quiet bit is signalling.
   assign inv_in   = (a_nan && !fa[MAN_W-1]) || (b_nan && !fb[MAN_W-1]) || inf_zero;
   assign cls_in   = (a_nan || b_nan || inf_zero) ? CLS_NAN  :
                     (a_inf || b_inf)             ? CLS_INF  :
                     (a_zero || b_zero)           ? CLS_ZERO : CLS_NUM;

   // Operation registers
   logic                    sign_q;
   logic signed [XE_W-1:0]  exp_q;
   logic [SIG_W-1:0]        ma_q, mb_q, mant_q;
   logic [PROD_W-1:0]       acc_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [2:0]              rm_q;
   logic [2:0]              grs_q;
   cls_t                    cls_q;
   logic                    inv_q;

   // Rounding / packing (combinational from the NORM results)
   logic                    rnd_inexact, rnd_inc, ovf_to_inf;
   logic [SUM_W-1:0]        rnd_sum;
   logic signed [XE_W-1:0]  rnd_exp;
   logic [MAN_W-1:0]        rnd_frac;
   logic [WIDTH-1:0]        rnd_result;
   logic [4:0]              rnd_flags;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples pre-edge values regardless of process order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every output of a combinational process gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = rst_n;
            if (in_valid) state_d = S_MUL;
         end
         S_MUL:  if (cnt_q == CNT_W'(MAN_W)) state_d = S_NORM;
         S_NORM: state_d = S_RND;
         S_RND:  state_d = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            // Returning to IDLE here means the next accept is a later edge.
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q <= 1'b0;
         exp_q  <= '0;
         ma_q   <= '0;
         mb_q   <= '0;
         mant_q <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         rm_q   <= '0;
         grs_q  <= '0;
         cls_q  <= CLS_NUM;
         inv_q  <= 1'b0;
         result <= '0;
         flags  <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
               exp_q  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
               ma_q   <= {1'b1, fa};
               mb_q   <= {1'b1, fb};
               acc_q  <= '0;
               cnt_q  <= '0;
               rm_q   <= rm;
               cls_q  <= cls_in;
               inv_q  <= inv_in;
            end
            S_MUL: begin
               if (ma_q[cnt_q]) acc_q <= acc_q + (PROD_W'(mb_q) << cnt_q);
               cnt_q <= cnt_q + CNT_W'(1);
            end
            S_NORM: begin
               // Product of two [1,2) significands lies in [1,4).
               if (acc_q[PROD_W-1]) begin
                  mant_q <= acc_q[PROD_W-1 -: SIG_W];
                  grs_q  <= {acc_q[MAN_W], acc_q[MAN_W-1], |acc_q[MAN_W-2:0]};
                  exp_q  <= exp_q + XE_W'(1);
               end else begin
                  mant_q <= acc_q[PROD_W-2 -: SIG_W];
                  grs_q  <= {acc_q[MAN_W-1], acc_q[MAN_W-2], |acc_q[MAN_W-3:0]};
               end
            end
            S_RND: begin
               result <= rnd_result;
               flags  <= rnd_flags;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rnd_inexact = |grs_q;
      case (rm_q)
         RM_RTZ:  rnd_inc = 1'b0;
         RM_RDN:  rnd_inc = sign_q && rnd_inexact;
         RM_RUP:  rnd_inc = !sign_q && rnd_inexact;
         RM_RMM:  rnd_inc = grs_q[2];
         default: rnd_inc = grs_q[2] && (grs_q[1] || grs_q[0] || mant_q[0]);
      endcase
      case (rm_q)
         RM_RTZ:  ovf_to_inf = 1'b0;
         RM_RDN:  ovf_to_inf = sign_q;
         RM_RUP:  ovf_to_inf = !sign_q;
         default: ovf_to_inf = 1'b1;
      endcase
      rnd_sum  = {1'b0, mant_q} + SUM_W'(rnd_inc);
      // A carry-out means the significand became 10.00..0: renormalise.
      rnd_exp  = exp_q + XE_W'(rnd_sum[SIG_W]);
      rnd_frac = rnd_sum[SIG_W] ? rnd_sum[MAN_W:1] : rnd_sum[MAN_W-1:0];

      rnd_result = '0;
      rnd_flags  = '0;
      case (cls_q)
         CLS_NAN:  rnd_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         CLS_INF:  rnd_result = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         CLS_ZERO: rnd_result = {sign_q, {(WIDTH-1){1'b0}}};
         default: begin
            if (rnd_exp >= EXP_MAX) begin
               rnd_flags[2] = 1'b1;
               rnd_flags[0] = 1'b1;
               rnd_result   = ovf_to_inf ?
                              {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                              {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            end else if (rnd_exp <= EXP_ZERO) begin
               rnd_flags[1] = 1'b1;
               rnd_flags[0] = 1'b1;
               rnd_result   = {sign_q, {(WIDTH-1){1'b0}}};
            end else begin
               rnd_flags[0] = rnd_inexact;
               rnd_result   = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
            end
         end
      endcase
      rnd_flags[4] = inv_q;
   end

endmodule
